// File: rtl/r2r_seq_pkg.sv
`default_nettype none
// ============================================================================
// r2r_seq_pkg : shared types for the R2R DAC wave sequencer
// Rev 1.0
// ============================================================================
package r2r_seq_pkg;

  localparam int CODE_W = 8;

  typedef enum logic [1:0] {
    MODE_EXT  = 2'd0,
    MODE_RAMP = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_FIFO = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/r2r_sample_fifo.sv
`default_nettype none
// ============================================================================
// r2r_sample_fifo : circular sample buffer feeding the FIFO wave source
// Rev 1.0
// ============================================================================
module r2r_sample_fifo
  import r2r_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [CODE_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              clr_i,
  output logic [CODE_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  // Full/empty come from registered occupancy, so a same-cycle pop never frees a slot early
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/r2r_wave_sequencer.sv
`default_nettype none
// ============================================================================
// r2r_wave_sequencer : sample-tick divider and DAC code source selector
// Rev 1.0
// ============================================================================
module r2r_wave_sequencer
  import r2r_seq_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_divider_i,
  input  logic [DIV_W-1:0]  div_value_i,
  input  logic [1:0]        mode_i,
  input  logic [CODE_W-1:0] step_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CODE_W-1:0] ext_data_i,
  input  logic              wr_valid_i,
  input  logic [CODE_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              fifo_clr_i,
  output logic [CODE_W-1:0] code_o,
  output logic              tick_o,
  output logic              busy_o,
  output logic              underrun_o
);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [CODE_W-1:0] step_q;
  logic [DIV_W-1:0]  period_q, cnt_q, cnt_d;
  logic [CODE_W-1:0] acc_q, acc_d, code_q, code_d;
  logic              dir_down_q, dir_down_d;
  logic              underrun_q, underrun_d;
  logic              start_fire;
  logic [CODE_W:0]   tri_sum;
  logic [CODE_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // stop has priority over start whenever both are asserted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i && !stop_i) state_d = ST_RUN;
      ST_RUN:  if (stop_i)             state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == ST_RUN);
    tick_o     = busy_o && (cnt_q == '0) && !stop_i;
    start_fire = (state_q == ST_IDLE) && start_i && !stop_i;
  end

  assign tri_sum = {1'b0, acc_q} + {1'b0, step_q};

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    dir_down_d = dir_down_q;
    code_d     = code_q;
    underrun_d = underrun_q;
    if (start_fire) begin
      cnt_d      = period_q;
      acc_d      = '0;
      dir_down_d = 1'b0;
      underrun_d = 1'b0;
    end else if (busy_o && !stop_i) begin
      cnt_d = (cnt_q == '0) ? period_q : cnt_q - DIV_W'(1);
    end
    if (tick_o) begin
      case (mode_q)
        MODE_EXT: code_d = ext_data_i;
        MODE_RAMP: begin
          code_d = acc_q;
          acc_d  = acc_q + step_q;
        end
        MODE_TRI: begin
          code_d = acc_q;
          // Saturate at the rails instead of wrapping, then reverse direction
          if (!dir_down_q) begin
            if (tri_sum >= 9'd255) begin
              acc_d      = 8'hFF;
              dir_down_d = 1'b1;
            end else begin
              acc_d = tri_sum[CODE_W-1:0];
            end
          end else if (acc_q <= step_q) begin
            acc_d      = '0;
            dir_down_d = 1'b0;
          end else begin
            acc_d = acc_q - step_q;
          end
        end
        MODE_FIFO: begin
          if (fifo_empty) underrun_d = 1'b1;
          else            code_d     = fifo_head;
        end
        default: code_d = code_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= MODE_EXT;
      step_q     <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      dir_down_q <= 1'b0;
      code_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (load_divider_i) period_q <= div_value_i;
      if (start_fire) begin
        mode_q <= mode_e'(mode_i);
        step_q <= step_i;
      end
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      dir_down_q <= dir_down_d;
      code_q     <= code_d;
      underrun_q <= underrun_d;
    end
  end

  r2r_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (wr_valid_i),
    .push_data_i(wr_data_i),
    .pop_i      (tick_o && (mode_q == MODE_FIFO)),
    .clr_i      (fifo_clr_i),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign wr_ready_o = !fifo_full;
  assign code_o     = code_q;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_r2r_wave_sequencer.sv
`default_nettype none
// ============================================================================
// tb_r2r_wave_sequencer : directed self-checking bench for the wave sequencer
// Rev 1.0
// ============================================================================
module tb_r2r_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_divider;
  logic [15:0] div_value;
  logic [1:0]  mode;
  logic [7:0]  step;
  logic        start, stop;
  logic [7:0]  ext_data;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        fifo_clr;
  logic [7:0]  code;
  logic        tick, busy, underrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r2r_wave_sequencer #(.DIV_W(16), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .load_divider_i(load_divider), .div_value_i(div_value),
    .mode_i(mode), .step_i(step), .start_i(start), .stop_i(stop), .ext_data_i(ext_data),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready), .fifo_clr_i(fifo_clr),
    .code_o(code), .tick_o(tick), .busy_o(busy), .underrun_o(underrun)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_divider = 1'b0; div_value = '0; mode = '0; step = '0;
    start = 1'b0; stop = 1'b0; ext_data = '0; wr_valid = 1'b0; wr_data = '0; fifo_clr = 1'b0;
    clk_step();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_divider = 1'b1; div_value = v;
    clk_step();
    load_divider = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] s);
    mode = m; step = s; start = 1'b1;
    clk_step();
    start = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    wr_valid = 1'b1; wr_data = d;
    clk_step();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (code !== 8'h00) begin bad++; $display("FAIL reset_code got=%h want=00", code); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
  endtask

  task automatic test_divider();
    logic       exp_tick;
    logic [7:0] exp_code;
    do_reset();
    do_load(16'd3);
    ext_data = 8'hA5;
    do_start(2'd0, 8'h00);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL div_busy got=%b want=1", busy); end
    for (int i = 0; i < 9; i++) begin
      exp_tick = (i == 3) || (i == 7);
      exp_code = (i >= 4) ? 8'hA5 : 8'h00;
      total++; if (tick !== exp_tick) begin bad++; $display("FAIL div_tick[%0d] got=%b want=%b", i, tick, exp_tick); end
      total++; if (code !== exp_code) begin bad++; $display("FAIL div_code[%0d] got=%h want=%h", i, code, exp_code); end
      clk_step();
    end
  endtask

  task automatic test_ramp();
    logic [7:0] exp_r [5];
    exp_r = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    do_reset();
    do_start(2'd1, 8'h40);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL ramp_first_tick got=%b want=1", tick); end
    clk_step();
    for (int i = 0; i < 5; i++) begin
      total++; if (code !== exp_r[i]) begin bad++; $display("FAIL ramp_code[%0d] got=%h want=%h", i, code, exp_r[i]); end
      clk_step();
    end
  endtask

  task automatic test_triangle();
    logic [7:0] exp_t [8];
    exp_t = '{8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
    do_reset();
    do_start(2'd2, 8'd100);
    clk_step();
    for (int i = 0; i < 8; i++) begin
      total++; if (code !== exp_t[i]) begin bad++; $display("FAIL tri_code[%0d] got=%0d want=%0d", i, code, exp_t[i]); end
      clk_step();
    end
    // step of zero must pin the triangle at 0
    stop = 1'b1; clk_step(); stop = 1'b0;
    do_start(2'd2, 8'd0);
    clk_step(); clk_step();
    for (int i = 0; i < 3; i++) begin
      total++; if (code !== 8'd0) begin bad++; $display("FAIL tri_step0[%0d] got=%0d want=0", i, code); end
      clk_step();
    end
  endtask

  task automatic test_fifo();
    logic [7:0] exp_code;
    logic       exp_und;
    do_reset();
    do_push(8'h11);
    do_push(8'h22);
    do_push(8'h33);
    do_load(16'd1);
    do_start(2'd3, 8'h00);
    for (int i = 0; i < 9; i++) begin
      exp_code = (i < 2) ? 8'h00 : (i < 4) ? 8'h11 : (i < 6) ? 8'h22 : 8'h33;
      exp_und  = (i == 8);
      total++; if (code !== exp_code) begin bad++; $display("FAIL fifo_code[%0d] got=%h want=%h", i, code, exp_code); end
      total++; if (underrun !== exp_und) begin bad++; $display("FAIL fifo_underrun[%0d] got=%b want=%b", i, underrun, exp_und); end
      clk_step();
    end
    stop = 1'b1; clk_step(); stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fifo_stop_busy got=%b want=0", busy); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL fifo_underrun_sticky got=%b want=1", underrun); end
    do_start(2'd3, 8'h00);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL fifo_underrun_clr got=%b want=0", underrun); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fifo_restart_busy got=%b want=1", busy); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int i = 0; i < 16; i++) do_push(8'h80 + 8'(i));
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%b want=0", wr_ready); end
    do_load(16'd2);
    wr_valid = 1'b1; wr_data = 8'hEE;
    do_start(2'd3, 8'h00);
    clk_step(); clk_step();
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL full_pop_tick got=%b want=1", tick); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_pop_cycle_ready got=%b want=0", wr_ready); end
    clk_step();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop_ready got=%b want=1", wr_ready); end
    total++; if (code !== 8'h80) begin bad++; $display("FAIL full_first_code got=%h want=80", code); end
    clk_step();
    wr_valid = 1'b0;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_refill_ready got=%b want=0", wr_ready); end
    clk_step(); clk_step();
    total++; if (code !== 8'h81) begin bad++; $display("FAIL full_second_code got=%h want=81", code); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 5; i++) do_push(8'h51 + 8'(i));
    do_start(2'd3, 8'h00);
    clk_step();
    total++; if (code !== 8'h51) begin bad++; $display("FAIL rst_pre_code got=%h want=51", code); end
    rst = 1'b1; clk_step(); rst = 1'b0;
    total++; if (code !== 8'h00) begin bad++; $display("FAIL rst_mid_code got=%h want=00", code); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_wr_ready got=%b want=1", wr_ready); end
    do_start(2'd3, 8'h00);
    clk_step();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL rst_mid_fifo_empty got=%b want=1", underrun); end
    total++; if (code !== 8'h00) begin bad++; $display("FAIL rst_mid_hold_code got=%h want=00", code); end
  endtask

  task automatic test_stop_start();
    do_reset();
    do_load(16'd3);
    ext_data = 8'h3C;
    do_start(2'd0, 8'h00);
    clk_step(); clk_step(); clk_step();
    stop = 1'b1; start = 1'b1;
    #1;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL stop_no_tick got=%b want=0", tick); end
    clk_step();
    stop = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", busy); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tick !== 1'b0 || code !== 8'h00) begin
        bad++; $display("FAIL stop_idle[%0d] tick=%b code=%h want tick=0 code=00", i, tick, code);
      end
      clk_step();
    end
  endtask

  initial begin
    do_reset();
    clk_step();
    test_reset();
    test_divider();
    test_ramp();
    test_triangle();
    test_fifo();
    test_full_fifo();
    test_reset_mid_run();
    test_stop_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/r2r_wave_sequencer.md
# r2r_wave_sequencer

Sample scheduler for the 8-bit R2R DAC: generates a programmable sample tick from the system clock and, on each tick, selects the next DAC code from one of four sources: external byte, ramp, triangle, or an internal sample FIFO. It sits between the pin-level control inputs and the level-shifting DAC drivers, replacing the free-running divider/mux control path. Its `code` output feeds the per-bit drivers directly.

## Interface
Parameters:
- `DIV_W`, 16, width of the sample-period divider.
- `FIFO_DEPTH`, 16, sample FIFO entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: single system clock (10 MHz nominal).
- `rst` in 1: reset, synchronous, active-high.
- `load_divider` in 1: one-cycle strobe; latches `div_value` into the period register.
- `div_value` in DIV_W: tick period minus one.
- `mode` in 2: source select, sampled at `start`. 0=EXT, 1=RAMP, 2=TRI, 3=FIFO.
- `step` in 8: ramp/triangle increment, sampled at `start`.
- `start` in 1: one-cycle strobe; IDLE→RUN.
- `stop` in 1: one-cycle strobe; RUN→IDLE.
- `ext_data` in 8: external sample, used in EXT mode.
- `wr_valid` in 1: FIFO push request.
- `wr_data` in 8: FIFO push data.
- `wr_ready` out 1: FIFO not full.
- `fifo_clr` in 1: empties the FIFO.
- `code` out 8: registered DAC code.
- `tick` out 1: one-cycle pulse per sample instant (the legacy `cnt_zero` function).
- `busy` out 1: state is RUN.
- `underrun` out 1: sticky; a FIFO-mode tick found the FIFO empty.

## Operation
- States:
  - IDLE: divider halted, `code` held.
  - RUN: divider counting.
- IDLE + `start` → RUN. This edge also:
  - latches `mode` and `step`;
  - loads the counter with the period register;
  - clears the accumulator and `underrun`;
  - sets the triangle direction to up.
- RUN + `stop` → IDLE. Takes effect on that edge, and no tick is generated in that cycle. `code` holds its last value.
- `start` in RUN and `stop` in IDLE are ignored. If `start` and `stop` are both asserted, `stop` wins.
- Divider in RUN: `tick`=1 when count==0; the counter then reloads from the period register. Otherwise it decrements.
- Tick period is period+1 cycles. Period 0 gives a tick every cycle.
- `load_divider` in RUN updates the period register only; the new value takes effect at the next reload.
- On each tick, selected by the latched mode:
  - EXT: `code`←`ext_data`.
  - RAMP: `code`←acc, then acc←acc+step mod 256.
  - TRI: `code`←acc.
    - Going up: if acc+step ≥255, acc←255 and direction←down; else acc←acc+step.
    - Going down: if acc ≤ step, acc←0 and direction←up; else acc←acc−step.
    - The addition is computed 9-bit, with no wrap.
  - FIFO: if not empty, `code`←head and the entry is popped. If empty, `code` holds and `underrun`←1.
- FIFO:
  - Push when `wr_valid`&&`wr_ready`, in any state.
  - `wr_ready`=!full, computed from registered occupancy. A pop in the same cycle does not admit a push into a full FIFO.
  - Push and pop in the same cycle on a non-empty, non-full FIFO leaves occupancy unchanged.
  - A pop attempt on an empty FIFO flags underrun, even if a push lands that cycle.
  - `fifo_clr` empties the FIFO and overrides any push or pop in that cycle.
- `step`=0: RAMP and TRI output a constant 0.

## Timing
- Reset values:
  - `code`=0x00, `tick`=0, `busy`=0, `underrun`=0.
  - FIFO empty, so `wr_ready`=1.
  - Period register=0, acc=0, direction=up.
- `rst` mid-RUN: everything returns to the reset values on that edge, including FIFO contents.
- `start` at edge N: `busy`=1 from cycle N+1. The first `tick` occurs in cycle N+1+P, where P is the period.
- `code` changes on the edge that ends the tick cycle, i.e. it is visible one cycle after `tick`.
- Push at edge N: data is poppable by a tick in cycle N+1 or later.

## Structure
- Package `r2r_seq_pkg` holds:
  - mode enum (EXT/RAMP/TRI/FIFO);
  - state enum (IDLE/RUN);
  - `CODE_W`=8.
- Sub-module `r2r_sample_fifo` holds the storage:
  - parameter `DEPTH`;
  - ports for push, pop, clear, head, empty, full;
  - occupancy counter of width log2(DEPTH)+1.
- The top-level holds the FSM, divider, accumulator and output mux.

## Test plan
- Divider: period=3, EXT mode, `ext_data`=0xA5, `start` → ticks every 4 cycles, first tick 4 cycles after RUN entry, `code`=0xA5 the cycle after.
- RAMP: step=0x40, period=0 → codes 0x00,0x40,0x80,0xC0,0x00 on consecutive cycles.
- TRI: step=100 → codes 0,100,200,255,155,55,0,100.
- FIFO:
  - Push 0x11,0x22,0x33 in FIFO mode, period=1 → codes 0x11,0x22,0x33.
  - The 4th tick holds 0x33 and sets `underrun`; the next `start` clears it.
- Full FIFO: push 16 entries → `wr_ready`=0. With `wr_valid` held through a same-cycle pop, that cycle's push is rejected and occupancy goes 16→15. The following cycle the push is accepted.
- Reset and stop: `rst` mid-RUN with 5 entries → `code`=0, `busy`=0, FIFO empty next cycle. `stop` and `start` in the same cycle while in RUN → IDLE and no tick.
